// File: rtl/pixel_sram_ctrl_p.sv
// rtl/pixel_sram_ctrl_p.sv - pixel buffer <-> SRAM burst mover with packed words and wait states
// Writes a burst from a snapshot of data_in, then reads a burst into data_out.
module pixel_sram_ctrl_p #(
  parameter  int ADDR_W       = 16,
  parameter  int PIX_W        = 8,
  parameter  int PIX_PER_WORD = 3,
  parameter  int BUF_PIX      = 20,
  parameter  int WAIT_CYC     = 2,
  localparam int WORD_W       = PIX_W * PIX_PER_WORD,
  localparam int CNT_W        = $clog2(BUF_PIX + 1)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_pix_write,
  input  logic [CNT_W-1:0]         num_pix_read,
  input  logic [ADDR_W-1:0]        address_write_offset,
  input  logic [ADDR_W-1:0]        address_read_offset,
  input  logic [BUF_PIX*PIX_W-1:0] data_in,
  output logic [BUF_PIX*PIX_W-1:0] data_out,
  output logic                     busy,
  output logic                     end_of_operations,
  output logic                     err,
  output logic [ADDR_W-1:0]        address,
  output logic [WORD_W-1:0]        w_data,
  input  logic [WORD_W-1:0]        r_data,
  output logic                     read_enable,
  output logic                     write_enable
);

  localparam int BUF_W  = BUF_PIX * PIX_W;
  localparam int WCNT_W = $clog2(WAIT_CYC + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(BUF_PIX);
  localparam logic [WCNT_W-1:0] LAST_EN = WCNT_W'(WAIT_CYC - 1);
  localparam logic [WCNT_W-1:0] TURN    = WCNT_W'(WAIT_CYC);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t              state_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [CNT_W-1:0]    word_q, nw_q, nr_q;
  logic [ADDR_W-1:0]   woff_q, roff_q, address_q;
  logic [BUF_W-1:0]    snap_q, data_out_q;
  logic [WORD_W-1:0]   w_data_q;
  logic                we_q, re_q, busy_q, eoo_q, err_q;

  logic [CNT_W-1:0]    word_d;
  logic [CNT_W:0]      words_w, words_r;
  logic [ADDR_W-1:0]   wr_addr_d, rd_addr_d;
  logic                more_w, more_r;

  function automatic logic [CNT_W:0] n_words(input logic [CNT_W-1:0] n);
    return ({1'b0, n} + (CNT_W+1)'(PIX_PER_WORD - 1)) / (CNT_W+1)'(PIX_PER_WORD);
  endfunction

  // Lanes past the requested pixel count are forced to zero.
  function automatic logic [WORD_W-1:0] pack(input logic [BUF_W-1:0] src,
                                             input logic [CNT_W-1:0] n,
                                             input logic [CNT_W-1:0] k);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int j = 0; j < PIX_PER_WORD; j++) begin
      if (int'(k) * PIX_PER_WORD + j < int'(n))
        w[j*PIX_W +: PIX_W] = src[(int'(k) * PIX_PER_WORD + j) * PIX_W +: PIX_W];
    end
    return w;
  endfunction

  always_comb begin
    word_d    = word_q + 1'b1;
    words_w   = n_words(nw_q);
    words_r   = n_words(nr_q);
    wr_addr_d = woff_q + ADDR_W'(word_d);
    rd_addr_d = roff_q + ADDR_W'(word_d);
    more_w    = {1'b0, word_d} < words_w;
    more_r    = {1'b0, word_d} < words_r;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      word_q     <= '0;
      nw_q       <= '0;
      nr_q       <= '0;
      woff_q     <= '0;
      roff_q     <= '0;
      address_q  <= '0;
      snap_q     <= '0;
      data_out_q <= '0;
      w_data_q   <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      busy_q     <= 1'b0;
      eoo_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          eoo_q   <= 1'b0;
          busy_q  <= 1'b0;
          if (start) begin
            nw_q   <= num_pix_write;
            nr_q   <= num_pix_read;
            woff_q <= address_write_offset;
            roff_q <= address_read_offset;
            snap_q <= data_in;
            word_q <= '0;
            wcnt_q <= '0;
            if (num_pix_write > MAX_CNT || num_pix_read > MAX_CNT) begin
              err_q <= 1'b1;
            end else if (num_pix_write != '0) begin
              state_q   <= WRITE;
              busy_q    <= 1'b1;
              we_q      <= 1'b1;
              address_q <= address_write_offset;
              w_data_q  <= pack(data_in, num_pix_write, '0);
            end else if (num_pix_read != '0) begin
              state_q   <= READ;
              busy_q    <= 1'b1;
              re_q      <= 1'b1;
              address_q <= address_read_offset;
            end else begin
              state_q <= DONE;
              eoo_q   <= 1'b1;
            end
          end
        end
        WRITE: begin
          wcnt_q <= wcnt_q + 1'b1;
          if (wcnt_q == LAST_EN) begin
            we_q      <= 1'b0;
            address_q <= '0;
            w_data_q  <= '0;
          end else if (wcnt_q == TURN) begin
            wcnt_q <= '0;
            word_q <= word_d;
            if (more_w) begin
              we_q      <= 1'b1;
              address_q <= wr_addr_d;
              w_data_q  <= pack(snap_q, nw_q, word_d);
            end else if (nr_q != '0) begin
              state_q   <= READ;
              word_q    <= '0;
              re_q      <= 1'b1;
              address_q <= roff_q;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              eoo_q   <= 1'b1;
            end
          end
        end
        READ: begin
          wcnt_q <= wcnt_q + 1'b1;
          if (wcnt_q == LAST_EN) begin
            re_q      <= 1'b0;
            address_q <= '0;
            for (int j = 0; j < PIX_PER_WORD; j++) begin
              if (int'(word_q) * PIX_PER_WORD + j < int'(nr_q))
                data_out_q[(int'(word_q) * PIX_PER_WORD + j) * PIX_W +: PIX_W] <= r_data[j*PIX_W +: PIX_W];
            end
          end else if (wcnt_q == TURN) begin
            wcnt_q <= '0;
            word_q <= word_d;
            if (more_r) begin
              re_q      <= 1'b1;
              address_q <= rd_addr_d;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              eoo_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out          = data_out_q;
  assign busy              = busy_q;
  assign end_of_operations = eoo_q;
  assign err               = err_q;
  assign address           = address_q;
  assign w_data            = w_data_q;
  assign read_enable       = re_q;
  assign write_enable      = we_q;

endmodule
